// File: rtl/bus_sequencer.sv
// Micro-sequencer for the 8-bit shared-bus datapath: accepts one macro-command
// over valid/ready and expands it into per-cycle control words on contr_s.
module bus_sequencer #(
  parameter int MODE_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_move,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic              cmd_src_a,
  input  logic              cmd_src_b,
  input  logic [1:0]        cmd_dst,
  output logic [MODE_W+6:0] contr_s,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cmd_count
);

  localparam int CW = MODE_W + 7;

  localparam int BIT_ALU_DRV = 6;
  localparam int BIT_WR_A    = 5;
  localparam int BIT_WR_B    = 4;
  localparam int BIT_WR_R3   = 3;
  localparam int BIT_R3_DRV  = 2;
  localparam int BIT_WR_R4   = 1;
  localparam int BIT_R4_DRV  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_MOVE
  } state_t;

  typedef struct packed {
    logic              move;
    logic [MODE_W-1:0] mode;
    logic              src_a;
    logic              src_b;
    logic [1:0]        dst;
  } cmd_t;

  state_t state, state_next;
  cmd_t   cmd_q;
  logic   accept;
  logic   finish;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign finish    = (state == S_EXEC) || (state == S_MOVE);

  // Source select: 0 picks the R3 driver, 1 picks the R4 driver.
  function automatic logic [CW-1:0] src_drive(input logic src);
    logic [CW-1:0] w;
    w = '0;
    if (src) w[BIT_R4_DRV] = 1'b1;
    else     w[BIT_R3_DRV] = 1'b1;
    return w;
  endfunction

  function automatic logic [CW-1:0] dst_write(input logic [1:0] dst);
    logic [CW-1:0] w;
    w = '0;
    w[BIT_WR_R3] = dst[0];
    w[BIT_WR_R4] = dst[1];
    return w;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the latched command fields are reset too, since the
  // reset contract covers them and they feed contr_s directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      done      <= 1'b0;
      cmd_count <= '0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (accept) begin
        cmd_q.move  <= cmd_move;
        cmd_q.mode  <= cmd_mode;
        cmd_q.src_a <= cmd_src_a;
        cmd_q.src_b <= cmd_src_b;
        cmd_q.dst   <= cmd_dst;
      end
      if (finish) cmd_count <= cmd_count + CNT_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept) state_next = cmd_move ? S_MOVE : S_LOAD_A;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_EXEC;
      S_EXEC:   state_next = S_IDLE;
      S_MOVE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control word is a function of state and latched fields only, so input
  // changes while busy never reach the bus.
  always_comb begin
    contr_s = '0;
    unique case (state)
      S_LOAD_A: begin
        contr_s           = src_drive(cmd_q.src_a);
        contr_s[BIT_WR_A] = 1'b1;
      end
      S_LOAD_B: begin
        contr_s           = src_drive(cmd_q.src_b);
        contr_s[BIT_WR_B] = 1'b1;
      end
      S_EXEC: begin
        contr_s                 = dst_write(cmd_q.dst);
        contr_s[BIT_ALU_DRV]    = 1'b1;
        contr_s[CW-1:CW-MODE_W] = cmd_q.mode;
      end
      S_MOVE: begin
        contr_s = src_drive(cmd_q.src_a) | dst_write(cmd_q.dst);
      end
      default: contr_s = '0;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: queue-based command model checked every
// cycle, a small bus datapath mock, and directed literal checks.
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_move;
  logic [3:0]  cmd_mode;
  logic        cmd_src_a;
  logic        cmd_src_b;
  logic [1:0]  cmd_dst;
  logic [10:0] contr_s;
  logic        busy;
  logic        done;
  logic [7:0]  cmd_count;

  bus_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_move  (cmd_move),
    .cmd_mode  (cmd_mode),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_dst   (cmd_dst),
    .contr_s   (contr_s),
    .busy      (busy),
    .done      (done),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath mock: one bus, A/B operand regs, R3/R4; the ALU simply adds.
  logic [7:0] r3, r4, ra, rb, bus;
  logic       dp_init = 1'b0;

  always_comb begin
    bus = 8'h00;
    if (contr_s[2])      bus = r3;
    else if (contr_s[0]) bus = r4;
    else if (contr_s[6]) bus = ra + rb;
  end

  always @(posedge clk) begin
    if (dp_init) begin
      r3 <= 8'h55;
      r4 <= 8'h2A;
    end else begin
      if (contr_s[5]) ra <= bus;
      if (contr_s[4]) rb <= bus;
      if (contr_s[3]) r3 <= bus;
      if (contr_s[1]) r4 <= bus;
    end
  end

  // Reference model: an accepted command becomes a list of future control words.
  function automatic logic [10:0] drv(input logic src);
    return src ? 11'h001 : 11'h004;
  endfunction

  function automatic logic [10:0] wr(input logic [1:0] d);
    return (d[0] ? 11'h008 : 11'h000) | (d[1] ? 11'h002 : 11'h000);
  endfunction

  logic [10:0] exp_q[$];
  logic        m_done   = 1'b0;
  logic [7:0]  m_count  = 8'h00;
  bit          model_on = 1'b0;
  bit          wr_seen  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_done   = 1'b0;
      m_count  = 8'h00;
      model_on = 1'b1;
    end else begin
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_done  = 1'b1;
          m_count = m_count + 8'd1;
        end
      end else if (cmd_valid) begin
        if (cmd_move) begin
          exp_q.push_back(drv(cmd_src_a) | wr(cmd_dst));
        end else begin
          exp_q.push_back(drv(cmd_src_a) | 11'h020);
          exp_q.push_back(drv(cmd_src_b) | 11'h010);
          exp_q.push_back({cmd_mode, 7'b0} | 11'h040 | wr(cmd_dst));
        end
      end
    end
  end

  logic [10:0] exp_w;

  always @(negedge clk) begin
    if (model_on) begin
      exp_w = (exp_q.size() != 0) ? exp_q[0] : 11'h000;
      check("contr_s", 32'(contr_s), 32'(exp_w));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() == 0));
      check("done", 32'(done), 32'(m_done));
      check("cmd_count", 32'(cmd_count), 32'(m_count));
      check("one_bus_driver", 32'($countones(contr_s & 11'h045) <= 1), 32'd1);
      if (!busy) check("idle_word_zero", 32'(contr_s), 32'd0);
      if (contr_s[3] || contr_s[1]) wr_seen = 1'b1;
    end
  end

  task automatic send(input logic mv, input logic [3:0] md, input logic sa,
                      input logic sb, input logic [1:0] d);
    int waited = 0;
    cmd_move  = mv;
    cmd_mode  = md;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_dst   = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check("ready_within_budget", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_move = 1'b0; cmd_mode = 4'h0;
    cmd_src_a = 1'b0; cmd_src_b = 1'b0; cmd_dst = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_contr_s", 32'(contr_s), 32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Reset during LOAD_B aborts the command with no writes and no done.
    wr_seen = 1'b0;
    send(1'b0, 4'h3, 1'b0, 1'b1, 2'b11);
    check("abort_load_a", 32'(contr_s), 32'h024);
    @(negedge clk);
    check("abort_load_b", 32'(contr_s), 32'h011);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_contr_s", 32'(contr_s), 32'h000);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_count", 32'(cmd_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_no_write", 32'(wr_seen), 32'd0);

    // ALU op: mode 1, A<-R3, B<-R4, result -> R3.
    send(1'b0, 4'b0001, 1'b0, 1'b1, 2'b01);
    check("alu_t1", 32'(contr_s), 32'h024);
    @(negedge clk);
    check("alu_t2", 32'(contr_s), 32'h011);
    @(negedge clk);
    check("alu_t3", 32'(contr_s), 32'h0C8);
    check("alu_t3_done", 32'(done), 32'd0);
    @(negedge clk);
    check("alu_t4_done", 32'(done), 32'd1);
    check("alu_t4_ready", 32'(cmd_ready), 32'd1);
    check("alu_t4_count", 32'(cmd_count), 32'd1);

    // Valid held through busy while the fields switch to a second command.
    cmd_move = 1'b0; cmd_mode = 4'h5; cmd_src_a = 1'b0; cmd_src_b = 1'b0;
    cmd_dst = 2'b10; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_move = 1'b1; cmd_mode = 4'hF; cmd_src_a = 1'b1; cmd_dst = 2'b01;
    check("hold_t1", 32'(contr_s), 32'h024);
    @(negedge clk);
    check("hold_t2", 32'(contr_s), 32'h014);
    @(negedge clk);
    check("hold_t3", 32'(contr_s), 32'h2C2);
    @(negedge clk);
    check("hold_t4_done", 32'(done), 32'd1);
    check("hold_t4_ready", 32'(cmd_ready), 32'd1);
    check("hold_t4_count", 32'(cmd_count), 32'd2);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_second_word", 32'(contr_s), 32'h009);
    @(negedge clk);
    check("hold_second_done", 32'(done), 32'd1);
    check("hold_second_count", 32'(cmd_count), 32'd3);

    // MOVE R4 -> R3 through the datapath mock.
    dp_init = 1'b1;
    @(negedge clk);
    dp_init = 1'b0;
    send(1'b1, 4'h0, 1'b1, 1'b0, 2'b01);
    check("move_word", 32'(contr_s), 32'h009);
    check("move_bus", 32'(bus), 32'h2A);
    @(negedge clk);
    check("move_r3", 32'(r3), 32'h2A);
    check("move_done", 32'(done), 32'd1);

    // 256 back-to-back MOVEs with no writeback wrap the counter.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 256; i++) send(1'b1, 4'h0, 1'(i), 1'b0, 2'b00);
    @(negedge clk);
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_count", 32'(cmd_count), 32'h00);
    check("wrap_no_write", 32'(wr_seen), 32'd0);

    // Random command mix with occasional idle gaps.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) @(negedge clk);
      send(1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 2'($urandom_range(3)));
    end
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
